// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM state encodings.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// The result is computed at accept time and held until the latency counter expires.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned W2         = 2 * WIDTH;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] phi, phi_n, plo, plo_n;
  logic [WIDTH-1:0] hi_q, hi_n, lo_q, lo_n;
  logic             busy_q, busy_n, done_q, done_n;

  logic [W2-1:0]    prod_s, prod_u;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [CNT_W-1:0] lat;
  logic             is_arith;

  // Low 2W bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (Op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (B == '0) begin
          res_lo = '1;
          res_hi = A;
        end else if (A == {1'b1, {(WIDTH-1){1'b0}}} && B == '1) begin
          res_lo = A;
          res_hi = '0;
        end else begin
          res_lo = WIDTH'($signed(A) / $signed(B));
          res_hi = WIDTH'($signed(A) % $signed(B));
        end
      end
      OP_DIVU: begin
        if (B == '0) begin
          res_lo = '1;
          res_hi = A;
        end else begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

  assign is_arith = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_DIV) || (Op == OP_DIVU);
  assign lat      = ((Op == OP_MULT) || (Op == OP_MULTU)) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      phi    <= '0;
      plo    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      phi    <= phi_n;
      plo    <= plo_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  // Counter holds remaining busy cycles; commit happens on the edge it reaches zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phi_n   = phi;
    plo_n   = plo;
    hi_n    = hi_q;
    lo_n    = lo_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start && !Cancel) begin
          if (is_arith) begin
            phi_n   = res_hi;
            plo_n   = res_lo;
            cnt_n   = lat;
            state_n = ST_RUN;
            busy_n  = 1'b1;
          end else if (Op == OP_MTHI) begin
            hi_n = A;
          end else if (Op == OP_MTLO) begin
            lo_n = A;
          end
        end
      end
      ST_RUN: begin
        if (Cancel) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt <= CNT_W'(1)) begin
          hi_n    = phi;
          lo_n    = plo;
          done_n  = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n  = cnt - CNT_W'(1);
          busy_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with default parameters.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, Cancel;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Cancel(Cancel), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one arithmetic op, measure the Busy window, then check the commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input logic [31:0] ehi,
                        input logic [31:0] elo, input bit mid_start);
    int n;
    bit both;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = OP_NOP; A = 32'hDEADBEEF; B = 32'h0;
    n = 0;
    both = 1'b0;
    while (Busy === 1'b1 && n < 64) begin
      n++;
      if (Done === 1'b1) both = 1'b1;
      if (mid_start && n == 2) begin
        Start = 1'b1; Op = OP_DIV; A = 32'h55; B = 32'h3;
      end else begin
        Start = 1'b0; Op = OP_NOP;
      end
      @(negedge Clk);
    end
    chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    chk({tag, "_overlap"}, 64'(both), 64'(0));
    chk({tag, "_hi"}, 64'(HI), 64'(ehi));
    chk({tag, "_lo"}, 64'(LO), 64'(elo));
    chk({tag, "_done"}, 64'(Done), 64'(1));
    @(negedge Clk);
    chk({tag, "_done_end"}, 64'(Done), 64'(0));
  endtask

  initial begin
    bit saw_done;
    Reset = 1'b0; Start = 1'b0; Cancel = 1'b0; Op = OP_NOP; A = '0; B = '0;
    #1;
    chk("rst_hi", 64'(HI), 64'(0));
    chk("rst_lo", 64'(LO), 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    @(negedge Clk);
    Reset = 1'b1;

    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("multu",     OP_MULTU, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA, 1'b1);
    run_op("mult_nn",   OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 5,  32'h00000000, 32'h0000000F, 1'b0);
    run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu",      OP_DIVU,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E, 1'b0);
    run_op("divu_zero", OP_DIVU,  32'd7,        32'd0,        10, 32'h00000007, 32'hFFFFFFFF, 1'b0);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div_zero",  OP_DIV,   32'd5,        32'd0,        10, 32'h00000005, 32'hFFFFFFFF, 1'b0);

    // Move-to registers take effect on the accept edge, no Busy, no Done.
    @(negedge Clk);
    Start = 1'b1; Op = OP_MTHI; A = 32'h12345678;
    @(negedge Clk);
    Start = 1'b0; Op = OP_NOP;
    chk("mthi_hi", 64'(HI), 64'(32'h12345678));
    chk("mthi_lo", 64'(LO), 64'(32'hFFFFFFFF));
    chk("mthi_busy", 64'(Busy), 64'(0));
    chk("mthi_done", 64'(Done), 64'(0));
    Start = 1'b1; Op = OP_MTLO; A = 32'hCAFEF00D;
    @(negedge Clk);
    Start = 1'b0; Op = OP_NOP;
    chk("mtlo_lo", 64'(LO), 64'(32'hCAFEF00D));
    chk("mtlo_hi", 64'(HI), 64'(32'h12345678));

    // NOP and undefined op code are ignored.
    Start = 1'b1; Op = OP_NOP; A = 32'h11111111;
    @(negedge Clk);
    Op = 3'd7;
    @(negedge Clk);
    Start = 1'b0; Op = OP_NOP;
    chk("nop_busy", 64'(Busy), 64'(0));
    chk("nop_hi", 64'(HI), 64'(32'h12345678));
    chk("nop_lo", 64'(LO), 64'(32'hCAFEF00D));

    // Cancel in IDLE beats a concurrent Start.
    Start = 1'b1; Cancel = 1'b1; Op = OP_MTHI; A = 32'h99999999;
    @(negedge Clk);
    Start = 1'b0; Cancel = 1'b0; Op = OP_NOP;
    chk("idle_cancel_hi", 64'(HI), 64'(32'h12345678));
    Start = 1'b1; Cancel = 1'b1; Op = OP_MULT; A = 32'd2; B = 32'd2;
    @(negedge Clk);
    Start = 1'b0; Cancel = 1'b0; Op = OP_NOP;
    chk("idle_cancel_busy", 64'(Busy), 64'(0));

    // Cancel during the third busy cycle of a MULT.
    Start = 1'b1; Op = OP_MULT; A = 32'd5; B = 32'd5;
    @(negedge Clk);
    Start = 1'b0; Op = OP_NOP;
    chk("cancel_busy1", 64'(Busy), 64'(1));
    @(negedge Clk);
    @(negedge Clk);
    Cancel = 1'b1;
    @(negedge Clk);
    Cancel = 1'b0;
    chk("cancel_busy", 64'(Busy), 64'(0));
    chk("cancel_done", 64'(Done), 64'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) saw_done = 1'b1;
    end
    chk("cancel_quiet", 64'(saw_done), 64'(0));
    chk("cancel_hi", 64'(HI), 64'(32'h12345678));
    chk("cancel_lo", 64'(LO), 64'(32'hCAFEF00D));

    // Asynchronous reset in the middle of a DIV.
    Start = 1'b1; Op = OP_DIV; A = 32'd100; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0; Op = OP_NOP;
    @(negedge Clk);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_hi", 64'(HI), 64'(0));
    chk("arst_lo", 64'(LO), 64'(0));
    chk("arst_busy", 64'(Busy), 64'(0));
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge Clk);
    chk("arst_discard_lo", 64'(LO), 64'(0));
    chk("arst_discard_busy", 64'(Busy), 64'(0));

    run_op("mult_after_rst", OP_MULT, 32'd3, 32'd4, 5, 32'h00000000, 32'h0000000C, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit with HI/LO registers. It serves the execute stage of the pipelined MIPS datapath. Width and per-operation latency are set by parameters. It raises Busy so the hazard logic can stall dependent MFHI/MFLO and any further mult/div instructions, and it accepts a Cancel for squashed instructions.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >= 8)
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>= 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>= 1)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (Reset = 0 resets)
Start  input  1  request from E stage; sampled at rising edge
Op  input  3  operation code (see Decomposition)
A  input  WIDTH  operand rs
B  input  WIDTH  operand rt
Cancel  input  1  abort in-flight op (E-stage flush)
Busy  output  1  operation in flight
Done  output  1  one-cycle pulse when HI/LO commit
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset (async, Reset=0): HI=0, LO=0, Busy=0, Done=0, counter=0, state IDLE. Takes effect immediately, including mid-operation. The pending result is discarded.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, down-counter active.
- IDLE, Start=1, Cancel=0, Op in {MULT, MULTU, DIV, DIVU} at edge k:
  - latch the result into pending PHI/PLO; load counter with latency L;
  - go to RUN; Busy=1 from after edge k.
- RUN: counter decrements each edge. At the edge where the counter reaches 0:
  - HI<=PHI, LO<=PLO; Busy<=0; Done<=1 for exactly one cycle; return to IDLE.
  - Busy is therefore high for exactly L cycles.
  - New HI/LO are visible the cycle Busy falls. Back-to-back ops: the next Start is accepted that same cycle.
- IDLE, Start=1, Op=MTHI: HI<=A at edge k. Op=MTLO: LO<=A at edge k. Busy stays 0, no Done.
- Start while Busy=1: ignored. The hazard unit must stall instead.
- Start with Op=NOP or an undefined code: ignored.
- Cancel=1 in RUN: next edge returns to IDLE. HI/LO unchanged, no Done, Busy=0 next cycle.
- Cancel=1 in IDLE with Start=1: Cancel wins and Start is ignored.
- Cancel=1 on the final RUN edge: Cancel wins, no commit.
- MULT: signed 2*WIDTH product. HI = upper WIDTH bits, LO = lower WIDTH bits.
- MULTU: unsigned 2*WIDTH product. HI = upper WIDTH bits, LO = lower WIDTH bits.
- DIV: signed, quotient truncated toward zero. LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
- DIVU: unsigned. LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO = all ones, HI = A. Normal latency.
- Signed overflow (A = most-negative, B = -1): LO = A, HI = 0.
- Operands are captured only at the accept edge. Later changes to A/B have no effect.
- Done and Busy are never both 1.

Decomposition:
- Shared header muldiv_defs.v, used by the controller and the hazard unit, defines the Op codes:
  - OP_NOP=3'd0, OP_MULT=3'd1, OP_MULTU=3'd2, OP_DIV=3'd3, OP_DIVU=3'd4, OP_MTHI=3'd5, OP_MTLO=3'd6.
- No sub-module. The arithmetic is a combinational block inside muldiv_unit, with the FSM and counter alongside it.

Test Plan:
- Defaults; MULT A=0xFFFFFFFE, B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done pulses 1 cycle.
- MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA. A Start issued mid-run is ignored (HI/LO and latency unaffected).
- DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=0x00000007.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678 -> HI updated next edge, Busy=0.
- MULT started, then Cancel on cycle 3 -> Busy=0 next cycle, HI/LO unchanged, no Done.
- Reset=0 asserted mid-DIV -> immediately HI=LO=0, Busy=0.
